rank_sorter: RTL

Parametrised sequential sorter that takes a vector of N unsigned W-bit values and returns them in descending order together with each value's original lane index. It generalises the fixed 3/4-input 16-bit greatest/second-greatest selection logic of the sorter datapath. It replaces that comparator tree with a single row of compare-exchange cells, reused over N odd-even transposition phases. The block sits between the input capture stage and the ranked-output consumers and uses valid/ready handshakes on both sides.

---
 rtl/rank_sorter.sv | 99 +++++++++
 1 files changed

// File: rtl/rank_sorter.sv
// rank_sorter: stable descending odd-even transposition sorter that also reports original lane indices.
// Optional macro SORTER_EARLY_EXIT_EN ends SORT early once the vector is known to be sorted.
module rank_sorter #(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int IW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N*IW-1:0] out_idx,
  output logic            busy
);
  localparam int PW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ph;
  logic [W-1:0] val [N];
  logic [W-1:0] val_nx [N];
  logic [IW-1:0] idx [N];
  logic [IW-1:0] idx_nx [N];
  logic last;
`ifdef SORTER_EARLY_EXIT_EN
  logic sw, sw_q;
`endif
  // One row of compare-exchange cells; phase parity picks which pairs are active.
  always_comb begin
    val_nx = val;
    idx_nx = idx;
`ifdef SORTER_EARLY_EXIT_EN
    sw = 1'b0;
`endif
    for (int i = 0; i < N - 1; i++)
      if ((i % 2) == int'(ph[0]) && val[i+1] > val[i]) begin
        val_nx[i]   = val[i+1];
        val_nx[i+1] = val[i];
        idx_nx[i]   = idx[i+1];
        idx_nx[i+1] = idx[i];
`ifdef SORTER_EARLY_EXIT_EN
        sw = 1'b1;
`endif
      end
  end
`ifdef SORTER_EARLY_EXIT_EN
  // Two quiet phases in a row (even and odd) mean no adjacent pair is out of order.
  assign last = (ph == PW'(N - 1)) || (!sw && ((N == 2) || (ph != '0 && !sw_q)));
`else
  assign last = ph == PW'(N - 1);
`endif
  always_comb begin
    state_nx = (state == IDLE && in_valid) ? SORT :
               (state == SORT && last)     ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ph    <= '0;
      for (int k = 0; k < N; k++) begin
        val[k] <= '0;
        idx[k] <= '0;
      end
`ifdef SORTER_EARLY_EXIT_EN
      sw_q <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        ph <= '0;
        for (int k = 0; k < N; k++) begin
          val[k] <= in_data[k*W +: W];
          idx[k] <= IW'(k);
        end
`ifdef SORTER_EARLY_EXIT_EN
        sw_q <= 1'b1;
`endif
      end else if (state == SORT) begin
        ph  <= ph + PW'(1);
        val <= val_nx;
        idx <= idx_nx;
`ifdef SORTER_EARLY_EXIT_EN
        sw_q <= sw;
`endif
      end
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_data[g*W +: W]   = val[g];
    assign out_idx[g*IW +: IW]  = idx[g];
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
endmodule
